// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs (ALU, load) drained round-robin
// into the register bank's single write port, with a pending-write scoreboard.
module regbank_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   write_en,
    output logic [ADDR_W-1:0]      reg_write_dest,
    output logic [DATA_W-1:0]      reg_write_data,
    output logic [(2**ADDR_W)-1:0] pending_mask,
    output logic                   idle
);

    localparam int NREG  = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NSRC  = 2;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    logic              valid_s   [NSRC];
    logic [ADDR_W-1:0] in_dest_s [NSRC];
    logic [DATA_W-1:0] in_data_s [NSRC];
    logic              ready_s   [NSRC];
    logic              push_s    [NSRC];
    logic              pop_s     [NSRC];

    logic [ADDR_W-1:0] fifo_dest_q [NSRC][DEPTH];
    logic [DATA_W-1:0] fifo_data_q [NSRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NSRC];
    logic [PTR_W-1:0]  wr_ptr_d [NSRC];
    logic [PTR_W-1:0]  rd_ptr_q [NSRC];
    logic [PTR_W-1:0]  rd_ptr_d [NSRC];
    logic [CNT_W-1:0]  count_q  [NSRC];
    logic [CNT_W-1:0]  count_d  [NSRC];

    grant_e            last_grant_q, last_grant_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   mask_s;

    // True when FIFO slot idx lies between the read pointer and read pointer + count.
    function automatic logic entry_live(input logic [PTR_W-1:0] idx,
                                        input logic [PTR_W-1:0] rd,
                                        input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] ofs;
        ofs = idx - rd;
        return ({1'b0, ofs} < cnt);
    endfunction

    function automatic logic [NREG-1:0] dest_onehot(input logic [ADDR_W-1:0] dest);
        return {{(NREG-1){1'b0}}, 1'b1} << dest;
    endfunction

    // Source mapping and push handshake; ready ignores the same-cycle pop.
    always_comb begin
        valid_s[0]   = alu_valid;
        in_dest_s[0] = alu_dest;
        in_data_s[0] = alu_data;
        valid_s[1]   = mem_valid;
        in_dest_s[1] = mem_dest;
        in_data_s[1] = mem_data;
        for (int s = 0; s < NSRC; s++) begin
            ready_s[s] = (count_q[s] < CNT_W'(DEPTH)) & rst;
            push_s[s]  = valid_s[s] & ready_s[s];
        end
    end

    // Round-robin grant on pre-edge occupancy and next port contents.
    always_comb begin
        pop_s[0]     = 1'b0;
        pop_s[1]     = 1'b0;
        last_grant_d = last_grant_q;
        write_en_d   = 1'b0;
        dest_d       = dest_q;
        data_d       = data_q;
        if ((count_q[0] != '0) && (count_q[1] != '0)) begin
            if (last_grant_q == GRANT_MEM) begin
                pop_s[0]     = 1'b1;
                last_grant_d = GRANT_ALU;
            end else begin
                pop_s[1]     = 1'b1;
                last_grant_d = GRANT_MEM;
            end
        end else if (count_q[0] != '0) begin
            pop_s[0] = 1'b1;
        end else if (count_q[1] != '0) begin
            pop_s[1] = 1'b1;
        end else begin
            pop_s[0] = 1'b0;
        end
        if (pop_s[0]) begin
            dest_d = fifo_dest_q[0][rd_ptr_q[0]];
            data_d = fifo_data_q[0][rd_ptr_q[0]];
        end else if (pop_s[1]) begin
            dest_d = fifo_dest_q[1][rd_ptr_q[1]];
            data_d = fifo_data_q[1][rd_ptr_q[1]];
        end else begin
            dest_d = dest_q;
        end
        // Register 0 is popped like any entry but never reaches the bank.
        write_en_d = (pop_s[0] | pop_s[1]) && (dest_d != '0);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            wr_ptr_d[s] = push_s[s] ? (wr_ptr_q[s] + PTR_W'(1)) : wr_ptr_q[s];
            rd_ptr_d[s] = pop_s[s]  ? (rd_ptr_q[s] + PTR_W'(1)) : rd_ptr_q[s];
            case ({push_s[s], pop_s[s]})
                2'b10:   count_d[s] = count_q[s] + CNT_W'(1);
                2'b01:   count_d[s] = count_q[s] - CNT_W'(1);
                default: count_d[s] = count_q[s];
            endcase
        end
    end

    // FIFO storage; contents are only meaningful inside the live window.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push_s[s]) begin
                fifo_dest_q[s][wr_ptr_q[s]] <= in_dest_s[s];
                fifo_data_q[s][wr_ptr_q[s]] <= in_data_s[s];
            end
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            last_grant_q <= GRANT_MEM;
            write_en_q   <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
            last_grant_q <= last_grant_d;
            write_en_q   <= write_en_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
        end
    end

    // Scoreboard: every queued non-zero destination plus the one on the port.
    always_comb begin
        mask_s = '0;
        for (int s = 0; s < NSRC; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_s = mask_s |
                    ((entry_live(PTR_W'(i), rd_ptr_q[s], count_q[s]) &&
                      (fifo_dest_q[s][i] != '0)) ? dest_onehot(fifo_dest_q[s][i]) : '0);
            end
        end
        mask_s = mask_s | (write_en_q ? dest_onehot(dest_q) : '0);
    end

    assign alu_ready      = ready_s[0];
    assign mem_ready      = ready_s[1];
    assign write_en       = write_en_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    assign pending_mask   = rst ? mask_s : '0;
    assign idle           = ~rst | ((count_q[0] == '0) & (count_q[1] == '0) & ~write_en_q);

endmodule
